// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard: per-register pending-writeback counters gate
// instruction issue (RAW on rs/rd, per-register saturation, total capacity).

module reg_scoreboard_cnt #(
    parameter int LEN_CNT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               inc,
    input  logic               dec,
    output logic [LEN_CNT-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst || flush)
            cnt <= '0;
        else if (inc && !dec)
            cnt <= cnt + LEN_CNT'(1);
        else if (dec && !inc)
            cnt <= cnt - LEN_CNT'(1);
    end
endmodule

module reg_scoreboard #(
    parameter int LEN_REGNO = 4,
    parameter int NUM_REG   = 16,
    parameter int LEN_CNT   = 2,
    parameter int LEN_TOTAL = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid_i,
    input  logic                 issue_rs_use_i,
    input  logic [LEN_REGNO-1:0] issue_rs_regno_i,
    input  logic                 issue_rd_use_i,
    input  logic                 issue_wb_i,
    input  logic [LEN_REGNO-1:0] issue_rd_regno_i,
    output logic                 issue_accept_o,
    output logic                 stall_o,
    input  logic                 wb_i,
    input  logic [LEN_REGNO-1:0] wb_regno_i,
    input  logic                 flush_i,
    output logic [NUM_REG-1:0]   busy_o,
    output logic [LEN_TOTAL-1:0] outstanding_o,
    output logic                 err_o
);
    localparam logic [LEN_CNT-1:0]   CNT_MAX   = '1;
    localparam logic [LEN_TOTAL-1:0] TOTAL_MAX = '1;

    logic [NUM_REG-1:0][LEN_CNT-1:0] cnt;
    logic [NUM_REG-1:0]              inc;
    logic [NUM_REG-1:0]              dec;
    logic [LEN_TOTAL-1:0]            total;
    logic                            err;

    logic raw_rs, raw_rd, sat, full;
    logic wb_live, issue_wb_acc, release_ok, release_bad, overflow;

    // Hazards look only at registered counters: no same-cycle writeback bypass.
    assign raw_rs = issue_rs_use_i && (cnt[issue_rs_regno_i] != '0);
    assign raw_rd = issue_rd_use_i && (cnt[issue_rd_regno_i] != '0);
    assign sat    = issue_wb_i && (cnt[issue_rd_regno_i] == CNT_MAX);
    assign full   = issue_wb_i && (total == TOTAL_MAX);

    assign issue_accept_o = issue_valid_i && !raw_rs && !raw_rd && !sat && !full && !flush_i;
    assign stall_o        = issue_valid_i && !issue_accept_o;

    assign wb_live      = (cnt[wb_regno_i] != '0);
    assign issue_wb_acc = issue_accept_o && issue_wb_i;
    assign release_ok   = wb_i && wb_live;
    assign release_bad  = wb_i && !wb_live && !flush_i;
    assign overflow     = issue_wb_acc && !release_ok && (total == TOTAL_MAX) && !flush_i;

    for (genvar n = 0; n < NUM_REG; n++) begin : g_reg
        assign inc[n] = issue_wb_acc && (issue_rd_regno_i == LEN_REGNO'(n));
        assign dec[n] = wb_i && (wb_regno_i == LEN_REGNO'(n)) && (cnt[n] != '0);

        reg_scoreboard_cnt #(.LEN_CNT(LEN_CNT)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .flush (flush_i),
            .inc   (inc[n]),
            .dec   (dec[n]),
            .cnt   (cnt[n])
        );

        assign busy_o[n] = (cnt[n] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total <= '0;
            err   <= 1'b0;
        end else begin
            if (flush_i)
                total <= '0;
            else if (issue_wb_acc && !release_ok)
                total <= total + LEN_TOTAL'(1);
            else if (release_ok && !issue_wb_acc)
                total <= total - LEN_TOTAL'(1);
            // Error is sticky across flush; only reset clears it.
            if (release_bad || overflow)
                err <= 1'b1;
        end
    end

    assign outstanding_o = total;
    assign err_o         = err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: driver pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.

module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid_i, issue_rs_use_i, issue_rd_use_i, issue_wb_i;
    logic [3:0] issue_rs_regno_i, issue_rd_regno_i, wb_regno_i;
    logic       issue_accept_o, stall_o, wb_i, flush_i, err_o;
    logic [15:0] busy_o;
    logic [5:0]  outstanding_o;

    reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid_i), .issue_rs_use_i(issue_rs_use_i),
        .issue_rs_regno_i(issue_rs_regno_i), .issue_rd_use_i(issue_rd_use_i),
        .issue_wb_i(issue_wb_i), .issue_rd_regno_i(issue_rd_regno_i),
        .issue_accept_o(issue_accept_o), .stall_o(stall_o),
        .wb_i(wb_i), .wb_regno_i(wb_regno_i), .flush_i(flush_i),
        .busy_o(busy_o), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        acc;
        logic        stall;
        logic [15:0] busy;
        logic [5:0]  outst;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: pending write counts per register, plain integers.
    int m_cnt[16];
    int m_total;
    bit m_err;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_total = 0;
        m_err = 0;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("accept", 16'(issue_accept_o), 16'(e.acc));
            chk("stall", 16'(stall_o), 16'(e.stall));
            chk("busy", busy_o, e.busy);
            chk("outstanding", 16'(outstanding_o), 16'(e.outst));
            chk("err", 16'(err_o), 16'(e.err));
        end
    end

    // Apply one cycle of inputs, queue the expected response, then advance the model.
    task automatic step(input logic v, input logic rsu, input logic [3:0] rs,
                        input logic rdu, input logic wbw, input logic [3:0] rd,
                        input logic wv, input logic [3:0] wr,
                        input logic fl, input logic r);
        exp_t e;
        bit acc, rel;
        issue_valid_i = v; issue_rs_use_i = rsu; issue_rs_regno_i = rs;
        issue_rd_use_i = rdu; issue_wb_i = wbw; issue_rd_regno_i = rd;
        wb_i = wv; wb_regno_i = wr; flush_i = fl; rst = r;
        acc = v && !(rsu && m_cnt[rs] > 0) && !(rdu && m_cnt[rd] > 0)
                && !(wbw && m_cnt[rd] == 3) && !(wbw && m_total == 63) && !fl;
        e.acc = acc;
        e.stall = v && !acc;
        for (int i = 0; i < 16; i++) e.busy[i] = (m_cnt[i] > 0);
        e.outst = 6'(m_total);
        e.err = m_err;
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (fl) begin
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_total = 0;
        end else begin
            rel = wv && m_cnt[wr] > 0;
            if (wv && m_cnt[wr] == 0) m_err = 1;
            if (acc && wbw) begin m_cnt[rd]++; m_total++; end
            if (rel) begin m_cnt[wr]--; m_total--; end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue_wb(input logic [3:0] rd);
        step(1, 0, 0, 0, 1, rd, 0, 0, 0, 0);
    endtask

    task automatic wb(input logic [3:0] r);
        step(0, 0, 0, 0, 0, 0, 1, r, 0, 0);
    endtask

    initial begin
        rst = 1; issue_valid_i = 0; issue_rs_use_i = 0; issue_rs_regno_i = 0;
        issue_rd_use_i = 0; issue_wb_i = 0; issue_rd_regno_i = 0;
        wb_i = 0; wb_regno_i = 0; flush_i = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        idle();

        // RAW on r3 cleared by writeback, one cycle after the release.
        step(1, 0, 1, 0, 1, 3, 0, 0, 0, 0);
        idle();
        step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0, 1, 3, 0, 0);
        step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);

        // WAW to r5 up to saturation.
        issue_wb(5); issue_wb(5); issue_wb(5);
        issue_wb(5);
        step(1, 0, 0, 0, 1, 5, 1, 5, 0, 0);
        issue_wb(5);
        idle();

        // Simultaneous issue and release on r2.
        issue_wb(2);
        step(1, 0, 0, 0, 1, 2, 1, 2, 0, 0);
        idle();

        // Release of an idle register sets sticky err.
        wb(7); idle(); idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // Flush with a pending issue.
        issue_wb(1); issue_wb(4); issue_wb(9);
        step(1, 1, 0, 0, 1, 6, 0, 0, 1, 0);
        idle();
        step(1, 1, 1, 1, 1, 4, 0, 0, 0, 0);

        // Reset with five writes outstanding.
        issue_wb(10); issue_wb(11); issue_wb(12); issue_wb(13);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 12, 1, 11, 0, 0, 0, 0, 0);
        step(1, 1, 4'(12), 1, 0, 4'(11), 0, 0, 0, 0);

        // Random traffic; releases mostly target reserved registers.
        for (int k = 0; k < 600; k++) begin
            logic [3:0] wr;
            int off;
            off = $urandom_range(15);
            wr = 4'(off);
            if ($urandom_range(9) < 8) begin
                for (int j = 0; j < 16; j++)
                    if (m_cnt[(off + j) % 16] > 0) begin
                        wr = 4'((off + j) % 16);
                        break;
                    end
            end
            step($urandom_range(3) != 0, 1'($urandom), 4'($urandom_range(7)),
                 1'($urandom), 1'($urandom_range(3) != 0), 4'($urandom_range(7)),
                 $urandom_range(2) == 0, wr,
                 $urandom_range(40) == 0, $urandom_range(150) == 0);
        end

        for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Register hazard scoreboard that sequences the in-order pipeline between instruction decode and writeback. It keeps a per-register count of outstanding writebacks and accepts a decoded instruction only when its sources are free. It produces the decode-stage stall, replacing the global writeback-reserved stall with per-register tracking. Writebacks release reservations; a flush clears all of them.

Parameters:
LEN_REGNO, 4, width of a register number
NUM_REG, 16, number of architectural registers (2**LEN_REGNO)
LEN_CNT, 2, width of each per-register pending counter; maximum CNT_MAX = 2**LEN_CNT-1
LEN_TOTAL, 6, width of the total outstanding-write counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
issue_valid_i  in  1  decoder presents an instruction this cycle
issue_rs_use_i  in  1  instruction reads rs
issue_rs_regno_i  in  LEN_REGNO  source register number
issue_rd_use_i  in  1  instruction reads rd
issue_wb_i  in  1  instruction will write rd
issue_rd_regno_i  in  LEN_REGNO  destination register number
issue_accept_o  out  1  instruction accepted this cycle (combinational)
stall_o  out  1  issue_valid_i & ~issue_accept_o (combinational)
wb_i  in  1  writeback completes this cycle
wb_regno_i  in  LEN_REGNO  register being written back
flush_i  in  1  discard all reservations
busy_o  out  NUM_REG  bit n = (cnt[n] != 0), registered
outstanding_o  out  LEN_TOTAL  total pending writebacks, registered
err_o  out  1  sticky: release of a non-reserved register, or total overflow

Behaviour:
- State: cnt[0..NUM_REG-1] (LEN_CNT bits each), total (LEN_TOTAL bits), err.
- Reset: all cnt = 0, total = 0, err = 0. Therefore busy_o = 0, outstanding_o = 0, err_o = 0. Reset overrides flush and all other inputs, including during activity.
- Hazard terms, evaluated on the registered counters only:
  - RAW_rs = rs_use & cnt[rs] != 0
  - RAW_rd = rd_use & cnt[rd] != 0
  - SAT = wb & cnt[rd] == CNT_MAX
  - FULL = wb & total == 2**LEN_TOTAL-1
- issue_accept_o = issue_valid_i & ~RAW_rs & ~RAW_rd & ~SAT & ~FULL & ~flush_i.
- No same-cycle bypass: a writeback in cycle N clears a hazard in cycle N+1 at the earliest.
- WAW is allowed: multiple pending writes to the same register are counted, up to CNT_MAX.
- Update each clock when rst=0:
  - flush_i=1: all cnt=0, total=0; issue and wb are ignored; err is kept.
  - Otherwise, for each register n: inc = accept & wb & rd==n; dec = wb_i & wb_regno_i==n & cnt[n]!=0.
    - inc & dec: cnt unchanged.
    - inc only: cnt+1.
    - dec only: cnt-1.
  - total changes by (+1 if an accepted wb issue) and (-1 if a valid release); the net is 0 when both occur.
  - wb_i to a register with cnt==0: no counter change, err set to 1.
- issue_rd == issue_rs with both used: a single hazard check, no double count.
- Latency: accept is 0-cycle combinational; the reservation is visible on busy_o in the next cycle.
- The decoder must hold its instruction stable while stall_o=1. The scoreboard keeps no copy of the stalled instruction.

Test Plan:
- Reset, then issue wb to r3 (rs=r1 unused): accept=1; next cycle busy_o=0x0008, outstanding_o=1. Then issue reading rs=r3: stall_o=1. Then wb_i r3: one cycle later the same issue gets accept=1.
- Three WAW issues to r5 (CNT_MAX=3): all accepted, cnt[5]=3. Fourth wb to r5: stall_o=1 (SAT). One wb_i r5: next cycle the fourth is accepted.
- Same cycle: accepted issue writing r2 plus wb_i r2 with cnt[2]=1: cnt[2] stays 1, outstanding_o unchanged.
- wb_i to r7 with cnt[7]=0: err_o=1 and stays high; busy_o and outstanding_o unchanged; rst clears err_o.
- With r1, r4 and r9 reserved, assert flush_i alongside a valid issue: accept=0; next cycle busy_o=0 and outstanding_o=0; the following issue is accepted.
- Assert rst while outstanding_o=5: next cycle all outputs are 0; an issue reading any register is accepted.
